axi_lite_master_bridge: RTL and testbench

//  Initiator-side AXI4 bridge: turns CPU single-word load/store requests into single-beat AXI4 transactions.
//  One instance per CPU port (IF -> M0, MEM -> M1), sitting between the pipeline core and the AXI interconnect.

---
 rtl/axi_pkg.sv | 24 ++
 rtl/axi_lite_master_bridge_if.sv | 76 +++++++
 rtl/axi_lite_master_bridge.sv | 162 ++++++++++++++++
 tb/tb_axi_lite_master_bridge.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 constants and the bridge FSM state type.
package axi_pkg;

  localparam int unsigned AXI_ADDR_BITS = 32;
  localparam int unsigned AXI_DATA_BITS = 32;
  localparam int unsigned AXI_ID_BITS   = 4;

  localparam logic [3:0] LEN_SINGLE = 4'd0;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_AR,
    RD_R,
    WR_AW_W,
    WR_B
  } bridge_state_e;

endpackage

// File: rtl/axi_lite_master_bridge_if.sv
// CPU request/response port plus the five AXI4 channels of one bridge instance.
interface axi_lite_master_bridge_if
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W = AXI_ADDR_BITS,
  parameter int unsigned DATA_W = AXI_DATA_BITS,
  parameter int unsigned ID_W   = AXI_ID_BITS
) ();

  localparam int unsigned STRB_W = DATA_W / 8;

  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              stall;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic [ID_W-1:0]   AWID;
  logic [ADDR_W-1:0] AWADDR;
  logic [3:0]        AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWVALID;
  logic              AWREADY;

  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;

  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;

  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [3:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;

  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output stall, resp_valid, resp_rdata, resp_err,
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input  BID, BRESP, BVALID, output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  stall, resp_valid, resp_rdata, resp_err,
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
  );

endinterface

// File: rtl/axi_lite_master_bridge.sv
// Turns single-word CPU loads/stores into single-beat AXI4 transactions,
// stalling the core until the R or B response returns (one outstanding).
module axi_lite_master_bridge
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W    = AXI_ADDR_BITS,
  parameter int unsigned DATA_W    = AXI_DATA_BITS,
  parameter int unsigned ID_W      = AXI_ID_BITS,
  parameter int unsigned MASTER_ID = 0
) (
  input logic                      clk,
  input logic                      rst,
  axi_lite_master_bridge_if.master bus
);

  localparam int unsigned STRB_W = DATA_W / 8;

  bridge_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              unused_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata_q      <= rdata_d;
    end
  end

  // VALID/READY are next-state registers, so no xREADY -> xVALID combinational path.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    rdata_d      = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wstrb_d = bus.req_wstrb;
          if (bus.req_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_AW_W;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_AR;
          end
        end
      end
      RD_AR: begin
        if (bus.ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (bus.RVALID) begin
          rready_d     = 1'b0;
          rdata_d      = bus.RDATA;
          resp_err_d   = (bus.RRESP != RESP_OKAY);
          resp_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end
      WR_AW_W: begin
        // A cleared VALID doubles as that channel's done flag.
        awvalid_d = awvalid_q & ~bus.AWREADY;
        wvalid_d  = wvalid_q & ~bus.WREADY;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_B;
        end
      end
      WR_B: begin
        if (bus.BVALID) begin
          bready_d     = 1'b0;
          resp_err_d   = (bus.BRESP != RESP_OKAY);
          resp_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Combinational stall lets the core hold its request during the accept cycle.
  assign bus.stall      = ~rst & ((state_q != IDLE) | bus.req_valid);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = resp_err_q;

  assign bus.AWID    = ID_W'(MASTER_ID);
  assign bus.AWADDR  = addr_q;
  assign bus.AWLEN   = LEN_SINGLE;
  assign bus.AWSIZE  = SIZE_WORD;
  assign bus.AWBURST = BURST_INCR;
  assign bus.AWVALID = awvalid_q;

  assign bus.WDATA  = wdata_q;
  assign bus.WSTRB  = wstrb_q;
  assign bus.WLAST  = 1'b1;
  assign bus.WVALID = wvalid_q;

  assign bus.BREADY = bready_q;

  assign bus.ARID    = ID_W'(MASTER_ID);
  assign bus.ARADDR  = addr_q;
  assign bus.ARLEN   = LEN_SINGLE;
  assign bus.ARSIZE  = SIZE_WORD;
  assign bus.ARBURST = BURST_INCR;
  assign bus.ARVALID = arvalid_q;

  assign bus.RREADY = rready_q;

  // IDs and RLAST carry no information with one outstanding single-beat transfer.
  assign unused_c = ^{bus.RID, bus.BID, bus.RLAST};

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench for axi_lite_master_bridge: loads, stores, channel skew,
// error responses, back-to-back requests and mid-transaction reset.
`define CHK(TAG, OBS, EXP) chk(TAG, 32'(OBS), 32'(EXP));

module tb_axi_lite_master_bridge;
  import axi_pkg::*;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  axi_lite_master_bridge_if bus ();

  axi_lite_master_bridge #(.MASTER_ID(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Protocol monitor: VALID held with stable payload until its handshake.
  logic        ar_pend, aw_pend, w_pend;
  logic [31:0] ar_addr_s, aw_addr_s, wdata_s;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_pend <= 1'b0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else begin
      if (ar_pend) begin
        checks++;
        if (bus.ARVALID !== 1'b1 || bus.ARADDR !== ar_addr_s) begin
          failures++;
          $display("FAIL mon_ar_hold observed=0x%0h expected=0x%0h", bus.ARADDR, ar_addr_s);
        end
      end
      if (aw_pend) begin
        checks++;
        if (bus.AWVALID !== 1'b1 || bus.AWADDR !== aw_addr_s) begin
          failures++;
          $display("FAIL mon_aw_hold observed=0x%0h expected=0x%0h", bus.AWADDR, aw_addr_s);
        end
      end
      if (w_pend) begin
        checks++;
        if (bus.WVALID !== 1'b1 || bus.WDATA !== wdata_s) begin
          failures++;
          $display("FAIL mon_w_hold observed=0x%0h expected=0x%0h", bus.WDATA, wdata_s);
        end
      end
      ar_pend   <= bus.ARVALID & ~bus.ARREADY;
      aw_pend   <= bus.AWVALID & ~bus.AWREADY;
      w_pend    <= bus.WVALID & ~bus.WREADY;
      ar_addr_s <= bus.ARADDR;
      aw_addr_s <= bus.AWADDR;
      wdata_s   <= bus.WDATA;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    bus.AWREADY = 1'b0;
    bus.WREADY  = 1'b0;
    bus.ARREADY = 1'b0;
    bus.BVALID  = 1'b0;
    bus.RVALID  = 1'b0;
  endtask

  task automatic cpu_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wstrb = s;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    slave_idle();
    bus.RID   = '0;
    bus.BID   = '0;
    bus.RLAST = 1'b1;
    bus.RDATA = '0;
    bus.RRESP = RESP_OKAY;
    bus.BRESP = RESP_OKAY;
    #1;
    `CHK("rst_arvalid", bus.ARVALID, 1'b0)
    `CHK("rst_awvalid", bus.AWVALID, 1'b0)
    `CHK("rst_wvalid", bus.WVALID, 1'b0)
    `CHK("rst_rready", bus.RREADY, 1'b0)
    `CHK("rst_bready", bus.BREADY, 1'b0)
    `CHK("rst_stall", bus.stall, 1'b0)
    `CHK("rst_resp_valid", bus.resp_valid, 1'b0)
    `CHK("rst_resp_err", bus.resp_err, 1'b0)
    `CHK("rst_rdata", bus.resp_rdata, 32'h0)
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 1: zero-wait load
    cpu_req(1'b0, 32'h0001_0004, 32'h0, 4'h0);
    #1;
    `CHK("t1_accept_stall", bus.stall, 1'b1)
    tick();
    `CHK("t1_arvalid", bus.ARVALID, 1'b1)
    `CHK("t1_araddr", bus.ARADDR, 32'h0001_0004)
    `CHK("t1_arlen", bus.ARLEN, 4'd0)
    `CHK("t1_arsize", bus.ARSIZE, 3'd2)
    `CHK("t1_arburst", bus.ARBURST, 2'b01)
    `CHK("t1_arid", bus.ARID, 4'd0)
    `CHK("t1_stall_c1", bus.stall, 1'b1)
    bus.ARREADY = 1'b1;
    tick();
    bus.ARREADY = 1'b0;
    `CHK("t1_arvalid_drop", bus.ARVALID, 1'b0)
    `CHK("t1_rready", bus.RREADY, 1'b1)
    `CHK("t1_no_early_resp", bus.resp_valid, 1'b0)
    bus.RVALID = 1'b1;
    bus.RDATA  = 32'hDEAD_BEEF;
    bus.RRESP  = RESP_OKAY;
    tick();
    `CHK("t1_resp_valid_c3", bus.resp_valid, 1'b1)
    `CHK("t1_rdata", bus.resp_rdata, 32'hDEAD_BEEF)
    `CHK("t1_resp_err", bus.resp_err, 1'b0)
    `CHK("t1_rready_drop", bus.RREADY, 1'b0)
    bus.RVALID    = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    `CHK("t1_stall_low", bus.stall, 1'b0)
    tick();
    `CHK("t1_resp_pulse", bus.resp_valid, 1'b0)
    `CHK("t1_rdata_held", bus.resp_rdata, 32'hDEAD_BEEF)

    // 2: store, AWREADY three cycles late, WREADY immediate
    cpu_req(1'b1, 32'h0001_0008, 32'hA5A5_1234, 4'b0011);
    tick();
    `CHK("t2_awvalid_c1", bus.AWVALID, 1'b1)
    `CHK("t2_wvalid_c1", bus.WVALID, 1'b1)
    `CHK("t2_awaddr_c1", bus.AWADDR, 32'h0001_0008)
    `CHK("t2_wdata", bus.WDATA, 32'hA5A5_1234)
    `CHK("t2_wstrb", bus.WSTRB, 4'b0011)
    `CHK("t2_wlast", bus.WLAST, 1'b1)
    `CHK("t2_awsize", bus.AWSIZE, 3'd2)
    `CHK("t2_awburst", bus.AWBURST, 2'b01)
    bus.WREADY = 1'b1;
    tick();
    bus.WREADY = 1'b0;
    `CHK("t2_wvalid_drop", bus.WVALID, 1'b0)
    `CHK("t2_awvalid_c2", bus.AWVALID, 1'b1)
    tick();
    `CHK("t2_awvalid_c3", bus.AWVALID, 1'b1)
    `CHK("t2_awaddr_c3", bus.AWADDR, 32'h0001_0008)
    `CHK("t2_bready_early", bus.BREADY, 1'b0)
    tick();
    `CHK("t2_awvalid_c4", bus.AWVALID, 1'b1)
    `CHK("t2_awaddr_c4", bus.AWADDR, 32'h0001_0008)
    bus.AWREADY = 1'b1;
    tick();
    bus.AWREADY = 1'b0;
    `CHK("t2_awvalid_drop", bus.AWVALID, 1'b0)
    `CHK("t2_bready", bus.BREADY, 1'b1)
    `CHK("t2_no_early_resp", bus.resp_valid, 1'b0)
    bus.BVALID = 1'b1;
    bus.BRESP  = RESP_OKAY;
    tick();
    `CHK("t2_resp_valid", bus.resp_valid, 1'b1)
    `CHK("t2_resp_err", bus.resp_err, 1'b0)
    `CHK("t2_rdata_kept", bus.resp_rdata, 32'hDEAD_BEEF)
    bus.BVALID    = 1'b0;
    bus.req_valid = 1'b0;
    tick();
    `CHK("t2_resp_pulse", bus.resp_valid, 1'b0)
    `CHK("t2_bready_drop", bus.BREADY, 1'b0)

    // 3a: AW first, W one cycle later, DECERR write response
    cpu_req(1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF);
    tick();
    bus.AWREADY = 1'b1;
    tick();
    bus.AWREADY = 1'b0;
    `CHK("t3a_awvalid_drop", bus.AWVALID, 1'b0)
    `CHK("t3a_wvalid_held", bus.WVALID, 1'b1)
    `CHK("t3a_bready_wait", bus.BREADY, 1'b0)
    bus.WREADY = 1'b1;
    tick();
    bus.WREADY = 1'b0;
    `CHK("t3a_wvalid_drop", bus.WVALID, 1'b0)
    `CHK("t3a_awvalid_stays", bus.AWVALID, 1'b0)
    `CHK("t3a_bready", bus.BREADY, 1'b1)
    bus.BVALID = 1'b1;
    bus.BRESP  = RESP_DECERR;
    tick();
    `CHK("t3a_resp_valid", bus.resp_valid, 1'b1)
    `CHK("t3a_resp_err", bus.resp_err, 1'b1)
    bus.BVALID    = 1'b0;
    bus.req_valid = 1'b0;
    tick();

    // 3b: AW and W handshakes in the same cycle
    cpu_req(1'b1, 32'h0000_0024, 32'h5566_7788, 4'hC);
    tick();
    bus.AWREADY = 1'b1;
    bus.WREADY  = 1'b1;
    tick();
    bus.AWREADY = 1'b0;
    bus.WREADY  = 1'b0;
    `CHK("t3b_awvalid_drop", bus.AWVALID, 1'b0)
    `CHK("t3b_wvalid_drop", bus.WVALID, 1'b0)
    `CHK("t3b_bready", bus.BREADY, 1'b1)
    bus.BVALID = 1'b1;
    bus.BRESP  = RESP_OKAY;
    tick();
    `CHK("t3b_resp_valid", bus.resp_valid, 1'b1)
    `CHK("t3b_resp_err", bus.resp_err, 1'b0)
    `CHK("t3b_no_dup_aw", bus.AWVALID, 1'b0)
    `CHK("t3b_no_dup_w", bus.WVALID, 1'b0)
    bus.BVALID    = 1'b0;
    bus.req_valid = 1'b0;
    tick();
    `CHK("t3b_resp_pulse", bus.resp_valid, 1'b0)

    // 4: load with SLVERR
    cpu_req(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    tick();
    bus.ARREADY = 1'b1;
    tick();
    bus.ARREADY = 1'b0;
    bus.RVALID  = 1'b1;
    bus.RDATA   = 32'h0BAD_0BAD;
    bus.RRESP   = RESP_SLVERR;
    tick();
    `CHK("t4_resp_valid", bus.resp_valid, 1'b1)
    `CHK("t4_resp_err", bus.resp_err, 1'b1)
    `CHK("t4_rdata", bus.resp_rdata, 32'h0BAD_0BAD)
    bus.RVALID    = 1'b0;
    bus.RRESP     = RESP_OKAY;
    bus.req_valid = 1'b0;
    #1;
    `CHK("t4_idle_stall", bus.stall, 1'b0)
    tick();

    // 5: load then store with req_valid held high across the boundary
    cpu_req(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    tick();
    `CHK("t5_stall_c1", bus.stall, 1'b1)
    bus.ARREADY = 1'b1;
    tick();
    bus.ARREADY = 1'b0;
    `CHK("t5_stall_c2", bus.stall, 1'b1)
    bus.RVALID = 1'b1;
    bus.RDATA  = 32'h5555_AAAA;
    tick();
    bus.RVALID = 1'b0;
    `CHK("t5_load_resp", bus.resp_valid, 1'b1)
    `CHK("t5_load_rdata", bus.resp_rdata, 32'h5555_AAAA)
    cpu_req(1'b1, 32'h0000_0104, 32'hFEED_0001, 4'hF);
    #1;
    `CHK("t5_accept_stall", bus.stall, 1'b1)
    tick();
    `CHK("t5_awvalid_gap1", bus.AWVALID, 1'b1)
    `CHK("t5_awaddr", bus.AWADDR, 32'h0000_0104)
    `CHK("t5_wdata", bus.WDATA, 32'hFEED_0001)
    `CHK("t5_resp_cleared", bus.resp_valid, 1'b0)
    bus.AWREADY = 1'b1;
    bus.WREADY  = 1'b1;
    tick();
    bus.AWREADY = 1'b0;
    bus.WREADY  = 1'b0;
    bus.BVALID  = 1'b1;
    tick();
    bus.BVALID = 1'b0;
    `CHK("t5_store_resp", bus.resp_valid, 1'b1)
    bus.req_valid = 1'b0;
    #1;
    `CHK("t5_stall_low", bus.stall, 1'b0)
    tick();

    // 6: reset while waiting in RD_R, then a clean load
    cpu_req(1'b0, 32'h0000_0200, 32'h0, 4'h0);
    tick();
    bus.ARREADY = 1'b1;
    tick();
    bus.ARREADY = 1'b0;
    `CHK("t6_rready_before", bus.RREADY, 1'b1)
    rst = 1'b1;
    #1;
    `CHK("t6_rst_rready", bus.RREADY, 1'b0)
    `CHK("t6_rst_arvalid", bus.ARVALID, 1'b0)
    `CHK("t6_rst_stall", bus.stall, 1'b0)
    `CHK("t6_rst_rdata", bus.resp_rdata, 32'h0)
    `CHK("t6_rst_resp_err", bus.resp_err, 1'b0)
    bus.req_valid = 1'b0;
    #2;
    rst = 1'b0;
    tick();
    `CHK("t6_idle_after", bus.stall, 1'b0)
    cpu_req(1'b0, 32'h0000_0300, 32'h0, 4'h0);
    tick();
    `CHK("t6_araddr", bus.ARADDR, 32'h0000_0300)
    `CHK("t6_arvalid", bus.ARVALID, 1'b1)
    bus.ARREADY = 1'b1;
    tick();
    bus.ARREADY = 1'b0;
    bus.RVALID  = 1'b1;
    bus.RDATA   = 32'hCAFE_F00D;
    tick();
    bus.RVALID = 1'b0;
    `CHK("t6_resp_valid", bus.resp_valid, 1'b1)
    `CHK("t6_rdata", bus.resp_rdata, 32'hCAFE_F00D)
    `CHK("t6_resp_err", bus.resp_err, 1'b0)
    bus.req_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
